// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : RV32M multiply/divide unit. Multiplies take one working cycle;
//               divides use a restoring divider with RISC-V special cases.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             abort,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int               c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [1:0]         r_sel;
    logic [WIDTH-1:0]   r_opa;      // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   r_opb;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   r_rem;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_signed_div;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_fix_q;
    logic [WIDTH-1:0]   w_fix_r;
    logic [WIDTH-1:0]   w_fix;

    // ------------------------------------------------------------------
    // Acceptance and divide special-case detection
    // ------------------------------------------------------------------
    assign w_accept     = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_signed_div = ~select[0];
    assign w_div_zero   = (data2 == '0);
    assign w_ovf        = w_signed_div && (data1 == c_min) && (data2 == '1);
    assign w_special    = w_div_zero || w_ovf;
    assign w_abs_a      = (w_signed_div && data1[WIDTH-1]) ? -data1 : data1;
    assign w_abs_b      = (w_signed_div && data2[WIDTH-1]) ? -data2 : data2;

    // ------------------------------------------------------------------
    // Multiplier: sign-extend to 2*WIDTH so one unsigned product serves all
    // ------------------------------------------------------------------
    assign w_a_sgn   = r_sel[0] ^ r_sel[1];
    assign w_b_sgn   = (r_sel == 2'b01);
    assign w_a_ext   = {{WIDTH{w_a_sgn & r_opa[WIDTH-1]}}, r_opa};
    assign w_b_ext   = {{WIDTH{w_b_sgn & r_opb[WIDTH-1]}}, r_opb};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_sel == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Restoring divide step and sign fix-up
    // ------------------------------------------------------------------
    assign w_rem_sh = {r_rem, r_opa[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_opb};
    assign w_fix_q  = r_neg_q ? -r_opa : r_opa;
    assign w_fix_r  = r_neg_r ? -r_rem : r_rem;
    assign w_fix    = r_sel[1] ? w_fix_r : w_fix_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        valid  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (!select[2]) begin
                        w_next = S_MUL;
                    end else if (w_special) begin
                        w_next = S_FIX;
                    end else begin
                        w_next = S_DIV;
                    end
                end else begin
                    w_next = S_IDLE;
                end
                valid = (r_state == S_DONE);
            end
            S_MUL: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_one) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_sel   <= select[1:0];
                r_opb   <= data2;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_cnt   <= '0;
                if (!select[2]) begin
                    r_opa <= data1;
                    r_rem <= '0;
                end else if (w_div_zero) begin
                    // Final quotient/remainder preloaded; FIX only selects.
                    r_opa <= '1;
                    r_rem <= data1;
                end else if (w_ovf) begin
                    r_opa <= data1;
                    r_rem <= '0;
                end else begin
                    r_opa   <= w_abs_a;
                    r_opb   <= w_abs_b;
                    r_rem   <= '0;
                    r_neg_q <= w_signed_div && (data1[WIDTH-1] ^ data2[WIDTH-1]);
                    r_neg_r <= w_signed_div && data1[WIDTH-1];
                    r_cnt   <= c_cnt_init;
                end
            end else if (r_state == S_DIV && !abort) begin
                r_opa <= {r_opa[WIDTH-2:0], ~w_trial[WIDTH]};
                r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_cnt <= r_cnt - c_cnt_one;
            end

            if (!abort && r_state == S_MUL) begin
                r_result <= w_mul_res;
            end
            if (!abort && r_state == S_FIX) begin
                r_result <= w_fix;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit with parametrised operand width and a start/valid handshake. It sits beside the single-cycle ALU in the EX stage and executes the full M-extension set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. Multiplies complete in one working cycle; divides use an iterative restoring algorithm and follow RISC-V semantics for divide-by-zero and signed overflow. The pipeline stalls on BUSY and can kill an in-flight operation with ABORT.

## Interface
- WIDTH, 32: operand and result width in bits; ≥ 4 and even.
- CLK  in  1  rising-edge clock.
- RESET  in  1  reset, asynchronous, active-high.
- START  in  1  request; accepted on an edge where START=1, BUSY=0, ABORT=0.
- SELECT  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  in  WIDTH  rs1 operand (dividend / multiplicand).
- DATA2  in  WIDTH  rs2 operand (divisor / multiplier).
- ABORT  in  1  synchronous flush of any in-flight operation.
- BUSY  out  1  operation in progress; new START ignored.
- VALID  out  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  out  WIDTH  last completed result; holds until the next VALID.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- BUSY is 1 in MUL, DIV and FIX, and 0 in IDLE and DONE.
- VALID is 1 only in DONE.
- Acceptance (from IDLE or DONE):
  - At the accepting edge, capture SELECT, DATA1 and DATA2 internally.
  - Input changes after that edge have no effect.
- Multiply path:
  - Accepting edge → MUL.
  - In MUL, form the 2·WIDTH-bit product with DATA1 signed for MULH/MULHSU, DATA2 signed for MULH only, and both unsigned for MULHU.
  - MUL returns product[WIDTH-1:0]; the other three return product[2·WIDTH-1:WIDTH].
  - Next edge: load RESULT → DONE.
- Divide path, normal case:
  - Accepting edge → DIV. Convert operands to magnitudes for signed ops; load the iteration counter with WIDTH.
  - Each DIV cycle performs one restoring step (shift remainder, trial-subtract, set quotient bit) and decrements the counter.
  - The edge that brings the counter to 0 → FIX.
- Divide path, special cases:
  - Detected at acceptance; they bypass DIV and go straight to FIX.
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give DATA1.
  - Signed overflow (DIV/REM with DATA1 = 100…0 and DATA2 = all-ones): DIV gives DATA1; REM gives 0.
- FIX:
  - Apply sign correction: quotient negated when the operand signs differ; remainder takes the sign of the dividend. Or substitute the special-case value.
  - Next edge: load RESULT → DONE.
- DONE:
  - START accepted → MUL/DIV/FIX as above (back-to-back issue).
  - Otherwise → IDLE.
- ABORT=1 at any edge:
  - Next state IDLE; RESULT unchanged; no VALID.
  - ABORT wins over a simultaneous START.
- RESET: state IDLE, BUSY=0, VALID=0, RESULT=0, counter=0 and internal operand registers=0, immediately and independent of CLK. Reset mid-operation discards the operation.
- Counter width is $clog2(WIDTH)+1.
- All arithmetic is modulo 2^WIDTH; no exceptions or flags are produced.

## Timing
- Call the accepting edge N.
- Multiply and divide special cases: VALID high from edge N+1 to edge N+2 (1-cycle busy).
- Normal divide: DIV occupies edges N+1…N+WIDTH, FIX ends at edge N+WIDTH+1, and VALID is high from N+WIDTH+1 to N+WIDTH+2. For WIDTH=32 that is 33 busy cycles.
- Throughput: one op per 2 cycles for multiply, and one per WIDTH+2 cycles for divide, when START is held high.
- BUSY rises at edge N and falls at the edge entering DONE.
- VALID and BUSY are never both 1.
- RESULT changes only at the edge entering DONE, or on RESET.

## Test plan
- Multiplies at WIDTH=32:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - Each gives VALID exactly one cycle after the accepting edge.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
  - VALID 33 cycles after acceptance; BUSY high throughout.
- Divide-by-zero and overflow:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All give VALID after 1 cycle.
- ABORT on the 10th DIV cycle:
  - No VALID; BUSY low after the next edge; RESULT keeps its prior value.
  - A following MUL 3×4 returns 12.
- Back-to-back: START held high with MUL 2×3 then DIV 9/3 → VALID with 6, then 3 accepted in the DONE cycle; START during BUSY is ignored.
- Asynchronous RESET asserted mid-DIV (between edges) → BUSY, VALID and RESULT go to 0 immediately; no VALID after release.
